counter_load_ctrl: RTL

Upstream control stage for the 4-bit loadable counter. It queues preset values received over a valid/ready interface. It watches the counter's current count and, when the count reaches a programmed terminal value, drives `load`/`load_data` so the counter reloads from the next queued preset on the same clock edge. It also reports queue level, an underrun pulse and a saturating reload tally.

---
 rtl/counter_load_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/counter_load_ctrl.sv
// Preset queue and terminal-count reload control for a loadable counter.
// Optional: define COUNTER_LOAD_CTRL_AUTO_RELOAD_EN to replay the last preset on an empty-queue hit.
module counter_load_ctrl #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int TALLY_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         term_value,
    input  logic                     preset_valid,
    input  logic [WIDTH-1:0]         preset_data,
    output logic                     preset_ready,
    input  logic [WIDTH-1:0]         count,
    output logic                     load,
    output logic [WIDTH-1:0]         load_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    output logic [TALLY_W-1:0]       reload_tally
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    typedef enum logic {IDLE, ARMED} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic               underrun_q;
    logic [TALLY_W-1:0] tally_q;

    logic hit, empty, push, pop, underrun_d;

`ifdef COUNTER_LOAD_CTRL_AUTO_RELOAD_EN
    logic [WIDTH-1:0] last_q;
    logic             last_vld_q;
`endif

    assign empty        = (level_q == '0);
    assign preset_ready = (level_q < DEPTH_L);
    assign hit          = (state_q == ARMED) && (count == term_value);
    assign push         = preset_valid && preset_ready;
    assign pop          = hit && !empty;

`ifdef COUNTER_LOAD_CTRL_AUTO_RELOAD_EN
    assign load       = hit && (!empty || last_vld_q);
    assign load_data  = empty ? last_q : mem_q[rd_ptr_q];
    assign underrun_d = hit && empty && !last_vld_q;
`else
    assign load       = pop;
    assign load_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign underrun_d = hit && empty;
`endif

    assign fifo_level   = level_q;
    assign underrun     = underrun_q;
    assign reload_tally = tally_q;

    // NOTE: queue storage has no reset; it is only read while level_q says an entry is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= preset_data;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            underrun_q <= 1'b0;
            tally_q    <= '0;
`ifdef COUNTER_LOAD_CTRL_AUTO_RELOAD_EN
            last_q     <= '0;
            last_vld_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE:    if (enable)  state_q <= ARMED;
                ARMED:   if (!enable) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase

            underrun_q <= underrun_d;

            if (load && (tally_q != '1)) begin
                tally_q <= tally_q + 1'b1;
            end

`ifdef COUNTER_LOAD_CTRL_AUTO_RELOAD_EN
            if (pop) begin
                last_q     <= mem_q[rd_ptr_q];
                last_vld_q <= 1'b1;
            end
`endif
        end
    end

endmodule
